// File: rtl/fifo_ctrl_16x16.sv
// Single-clock FIFO controller for an external 16x16 dual-port RAM.
// Port A writes, port B reads; the RAM read data is valid one edge after enb.
module fifo_ctrl_16x16 #(
  parameter int DW = 16,
  parameter int AW = 4
) (
  input  logic          clka,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] din,
  input  logic          rd_en,
  input  logic          flush,
  input  logic          clr_err,
  output logic          ena,
  output logic          wea,
  output logic [AW-1:0] ada,
  output logic [DW-1:0] dina,
  output logic          enb,
  output logic          web,
  output logic [AW-1:0] adb,
  output logic [DW-1:0] dinb,
  input  logic [DW-1:0] outb,
  output logic [DW-1:0] dout,
  output logic          rd_valid,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          underflow
);

  localparam logic [AW:0] DEPTH = (AW+1)'(2**AW);

  typedef struct packed {
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   cnt;
  } fifo_st_t;

  fifo_st_t st;
  logic     rd_vld;
  logic     wr_acc, rd_acc;
  logic     ovf_set, udf_set;

  assign full  = (st.cnt == DEPTH);
  assign empty = (st.cnt == '0);
  assign count = st.cnt;

  // rst is folded into the accepts so a reset cycle never reaches the RAM
  assign wr_acc = wr_en & ~full  & ~flush & ~rst;
  assign rd_acc = rd_en & ~empty & ~flush & ~rst;

  assign ovf_set = wr_en & full  & ~flush;
  assign udf_set = rd_en & empty & ~flush;

  assign ena  = wr_acc;
  assign wea  = wr_acc;
  assign ada  = st.wptr;
  assign dina = din;

  assign enb  = rd_acc;
  assign web  = 1'b0;
  assign adb  = st.rptr;
  assign dinb = '0;

  assign dout     = outb;
  assign rd_valid = rd_vld;

  always_ff @(posedge clka) begin
    if (rst) begin
      st        <= '0;
      rd_vld    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      // rd_acc is already low during flush, so rd_vld clears with it
      rd_vld <= rd_acc;
      if (flush) begin
        st <= '0;
      end else begin
        if (wr_acc) st.wptr <= st.wptr + AW'(1);
        if (rd_acc) st.rptr <= st.rptr + AW'(1);
        case ({wr_acc, rd_acc})
          2'b10:   st.cnt <= st.cnt + (AW+1)'(1);
          2'b01:   st.cnt <= st.cnt - (AW+1)'(1);
          default: st.cnt <= st.cnt;
        endcase
      end
      // set beats clear when both land on the same edge
      overflow  <= ovf_set | (overflow  & ~clr_err);
      underflow <= udf_set | (underflow & ~clr_err);
    end
  end

endmodule

// File: tb/tb_fifo_ctrl_16x16.sv
// Directed + randomized bench for fifo_ctrl_16x16 with a behavioural RAM
// and a queue-based reference FIFO.
module tb_fifo_ctrl_16x16;
  localparam int DW = 16;
  localparam int AW = 4;

  logic          clka = 1'b0;
  logic          rst, wr_en, rd_en, flush, clr_err;
  logic [DW-1:0] din;
  logic          ena, wea, enb, web;
  logic [AW-1:0] ada, adb;
  logic [DW-1:0] dina, dinb, outb, dout;
  logic          rd_valid, full, empty, overflow, underflow;
  logic [AW:0]   count;

  fifo_ctrl_16x16 #(.DW(DW), .AW(AW)) dut (
    .clka(clka), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .flush(flush), .clr_err(clr_err), .ena(ena), .wea(wea), .ada(ada),
    .dina(dina), .enb(enb), .web(web), .adb(adb), .dinb(dinb), .outb(outb),
    .dout(dout), .rd_valid(rd_valid), .full(full), .empty(empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clka = ~clka;

  // RAM: synchronous write on A, registered read on B
  logic [DW-1:0] mem [0:15];
  always @(posedge clka) begin
    if (ena && wea) mem[ada] <= dina;
    if (enb) outb <= mem[adb];
  end

  // reference model
  logic [DW-1:0] q[$];
  int            wr_total, rd_total;
  bit            m_ovf, m_udf, m_vld;
  logic [DW-1:0] m_dout;
  bit            last_wacc, last_racc;
  int            passed = 0, total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    q.delete();
    wr_total = 0; rd_total = 0;
    m_vld = 0;
  endtask

  // one clock: drive, check port A/B before the edge, check state after it
  task automatic step(input bit w, input logic [DW-1:0] d, input bit r,
                      input bit fl = 0, input bit ce = 0, input bit rs = 0);
    bit m_full, m_empty, wacc, racc;
    wr_en = w; din = d; rd_en = r; flush = fl; clr_err = ce; rst = rs;
    #1;
    m_full  = (q.size() == 16);
    m_empty = (q.size() == 0);
    wacc = w && !m_full  && !fl && !rs;
    racc = r && !m_empty && !fl && !rs;
    last_wacc = wacc; last_racc = racc;
    chk("ena", ena, wacc);
    chk("wea", wea, wacc);
    chk("ada", ada, wr_total % 16);
    if (wacc) chk("dina", dina, d);
    chk("enb", enb, racc);
    chk("web", web, 0);
    chk("adb", adb, rd_total % 16);
    @(posedge clka); #1;
    if (rs) begin
      model_reset(); m_ovf = 0; m_udf = 0;
    end else begin
      m_ovf = (w && m_full  && !fl) || (m_ovf && !ce);
      m_udf = (r && m_empty && !fl) || (m_udf && !ce);
      if (fl) model_reset();
      else begin
        m_vld = racc;
        if (racc) begin m_dout = q.pop_front(); rd_total++; end
        if (wacc) begin q.push_back(d); wr_total++; end
      end
    end
    chk("count", count, q.size());
    chk("count_le16", (count <= 16), 1);
    chk("full", full, q.size() == 16);
    chk("empty", empty, q.size() == 0);
    chk("rd_valid", rd_valid, m_vld);
    if (m_vld) chk("dout", dout, m_dout);
    chk("overflow", overflow, m_ovf);
    chk("underflow", underflow, m_udf);
    @(negedge clka);
  endtask

  initial begin
    int nw, nr, iter;
    wr_en = 0; rd_en = 0; flush = 0; clr_err = 0; din = '0; rst = 1;
    m_ovf = 0; m_udf = 0; m_dout = '0;
    model_reset();
    @(posedge clka); @(negedge clka);
    step(0, 0, 0, 0, 0, 1);
    chk("reset_ada", ada, 0);
    chk("reset_adb", adb, 0);

    // two writes, two reads
    step(1, 16'd852, 0);
    step(1, 16'd34, 0);
    chk("cnt2", count, 2);
    step(0, 0, 1);
    step(0, 0, 1);
    step(0, 0, 0);
    chk("empty_after_rw", empty, 1);

    // 17 writes from empty: last rejected, overflow sticks until clr_err
    for (int i = 0; i < 17; i++) step(1, 16'(100 + i), 0);
    chk("ovf_set", overflow, 1);
    step(0, 0, 0);
    chk("ovf_hold", overflow, 1);
    // full + wr + rd: read wins, returns word 100
    step(1, 16'hBEEF, 1);
    chk("both_full_cnt", count, 15);
    step(0, 0, 0, 0, 1);
    chk("ovf_clr", overflow, 0);
    step(0, 0, 0, 1);

    // read on empty
    step(0, 0, 1);
    chk("udf_set", underflow, 1);
    // empty + wr + rd with clr_err: write wins, no fall-through
    step(1, 16'h1234, 1, 0, 1);
    chk("both_empty_cnt", count, 1);
    step(0, 0, 0, 1);

    // random traffic, 20 in / 20 out
    nw = 0; nr = 0; iter = 0;
    while ((nw < 20 || nr < 20) && iter < 500) begin
      step(nw < 20 && $urandom_range(0, 2) != 0, 16'($urandom_range(0, 65535)),
           nr < 20 && $urandom_range(0, 2) == 0);
      if (last_wacc) nw++;
      if (last_racc) nr++;
      iter++;
    end
    total++;
    if (nw == 20 && nr == 20) passed++;
    else $error("FAIL random_budget observed=%0d/%0d expected=20/20", nw, nr);
    chk("wrap_wr", wr_total, 20);

    // flush at count 5 with wr_en high
    for (int i = 0; i < 5; i++) step(1, 16'(200 + i), 0);
    chk("cnt5", count, 5);
    step(1, 16'h5555, 1, 1);
    chk("flush_empty", empty, 1);
    // reset mid-burst
    for (int i = 0; i < 3; i++) step(1, 16'(300 + i), i == 2);
    step(1, 16'h7777, 1, 0, 0, 1);
    chk("rst_mid_cnt", count, 0);
    step(0, 0, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fifo_ctrl_16x16.md
FIFO_CTRL_16X16 -- requirements
Module: fifo_ctrl_16x16

Interface
REQ-001 The block SHALL have parameter DW, 16, data width in bits, matching the RAM word width.
REQ-002 The block SHALL have parameter AW, 4, address width in bits; depth = 2**AW = 16 words.
REQ-003 The block SHALL have port clka  input  1  single clock, rising-edge, also driving both RAM ports (clka, clkb).
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port wr_en  input  1  producer write request.
REQ-006 The block SHALL have port din  input  DW  producer write data.
REQ-007 The block SHALL have port rd_en  input  1  consumer read request.
REQ-008 The block SHALL have port flush  input  1  synchronous FIFO clear.
REQ-009 The block SHALL have port clr_err  input  1  clears sticky error flags.
REQ-010 The block SHALL have ports ena, wea  output  1 each  RAM port A enable and write enable.
REQ-011 The block SHALL have ports ada  output  AW  and  dina  output  DW  RAM port A address and write data.
REQ-012 The block SHALL have ports enb, web  output  1 each  RAM port B enable and write enable.
REQ-013 The block SHALL have ports adb  output  AW  and  dinb  output  DW  RAM port B address and write data.
REQ-014 The block SHALL have port outb  input  DW  RAM port B read data, valid one clka edge after enb.
REQ-015 The block SHALL have ports dout  output  DW  and  rd_valid  output  1  consumer read data and its qualifier.
REQ-016 The block SHALL have ports full, empty  output  1 each  and  count  output  AW+1  occupancy status.
REQ-017 The block SHALL have ports overflow, underflow  output  1 each  sticky error flags.

Function
REQ-018 Write accept SHALL be wr_acc = wr_en & ~full & ~flush & ~rst; read accept SHALL be rd_acc = rd_en & ~empty & ~flush & ~rst.
REQ-019 Port A SHALL be combinational: ena = wea = wr_acc, ada = wptr, dina = din.
REQ-020 Port B SHALL be read-only: enb = rd_acc, web = 0, adb = rptr, dinb = 0.
REQ-021 wptr (AW bits) SHALL increment on wr_acc and wrap 15 -> 0; rptr likewise on rd_acc.
REQ-022 count SHALL be +1 on wr_acc only, -1 on rd_acc only, and unchanged on both or neither; range 0..16.
REQ-023 full SHALL equal (count == 16); empty SHALL equal (count == 0); both are derived from registered count.
REQ-024 rd_valid SHALL be rd_acc registered by one edge; dout SHALL equal outb; dout is meaningful only while rd_valid = 1.
REQ-025 At full with wr_en and rd_en both high, the read SHALL be accepted, the write rejected, and count SHALL go to 15.
REQ-026 At empty with wr_en and rd_en both high, the write SHALL be accepted, the read rejected, and count SHALL go to 1; there is no fall-through.
REQ-027 overflow SHALL set on any edge with wr_en & full & ~flush; underflow SHALL set on any edge with rd_en & empty & ~flush.
REQ-028 The flags SHALL hold until clr_err or rst; if a set condition and clr_err coincide, set SHALL win.
REQ-029 flush SHALL, at the next edge, zero wptr, rptr, count and rd_valid, and SHALL suppress ena/enb in its cycle.
REQ-030 flush SHALL have priority over wr_en/rd_en and SHALL NOT alter the error flags.
REQ-031 RAM contents SHALL NOT be cleared by flush or rst; stale data is unreachable because the pointers are reset.

Reset
REQ-032 On a clka edge with rst = 1, the block SHALL set wptr = rptr = 0, count = 0, rd_valid = 0, overflow = underflow = 0.
REQ-033 While rst = 1, ena, wea, enb and web SHALL be 0, so a reset mid-operation aborts any in-flight write.
REQ-034 Reset state outputs SHALL be: empty = 1, full = 0, count = 0, ada = adb = 0.

Verification
REQ-035 Bench: write 852 then 34 (wr_en 2 cycles) -> ada = 0, 1 with wea = 1; count = 2; then rd_en 2 cycles -> adb = 0, 1; rd_valid high one cycle later with dout = 852 then 34; empty = 1.
REQ-036 Bench: write 17 words continuously from empty -> 16 accepted; full = 1 after 16th; 17th has wea = 0; overflow = 1 and remains until clr_err pulse.
REQ-037 Bench: rd_en on empty -> enb = 0, rd_valid stays 0, underflow = 1, count stays 0.
REQ-038 Bench: fill to 16, assert wr_en + rd_en together -> count = 15, full = 0, read returns first-written word.
REQ-039 Bench: write 20 + read 20 words with random gaps -> pointers wrap; data order preserved; count never exceeds 16.
REQ-040 Bench: count = 5, assert flush with wr_en = 1 -> wea = 0 that cycle; next edge count = 0, empty = 1; rst mid-burst -> same reset values next edge.
